// File: rtl/npu_cmd_pkg.sv
// Shared constants and types for the NPU command scheduler: command bytes,
// engine kind encodings, FSM states, status bit positions and queue entry layout.
package npu_cmd_pkg;

    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_COMPUTE = 8'h02;
    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_CLR_ERR = 8'hFF;

    localparam logic [1:0] KIND_WRITE   = 2'd1;
    localparam logic [1:0] KIND_COMPUTE = 2'd2;
    localparam logic [1:0] KIND_READ    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    localparam int STAT_BUSY    = 7;
    localparam int STAT_OVF     = 6;
    localparam int STAT_ILLEGAL = 5;
    localparam int STAT_TIMEOUT = 4;
    localparam int STAT_FULL    = 3;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] tile_i;
        logic [2:0] tile_j;
        logic [2:0] op;
        logic [7:0] data;
    } cmd_entry_t;

    localparam int ENTRY_W = $bits(cmd_entry_t);

endpackage

// File: rtl/cmd_fifo.sv
// Command queue: synchronous FIFO whose read port always presents the head entry,
// so a pop and the capture of the head happen on the same edge.
module cmd_fifo
    import npu_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CW-1:0]      count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/npu_cmd_scheduler.sv
// NPU command scheduler: synchronises SPI frames, queues legal commands and
// issues them one at a time to the tile engine over req/ack + done.
module npu_cmd_scheduler
    import npu_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_valid,
    input  logic [7:0] frame_cmd,
    input  logic [2:0] frame_tile_i,
    input  logic [2:0] frame_tile_j,
    input  logic [2:0] frame_op,
    input  logic [7:0] frame_data,
    output logic       eng_req,
    output logic [1:0] eng_kind,
    output logic [2:0] eng_op,
    output logic [2:0] eng_tile_i,
    output logic [2:0] eng_tile_j,
    output logic [7:0] eng_data,
    input  logic       eng_ack,
    input  logic       eng_done,
    input  logic [7:0] eng_result,
    output logic [7:0] status,
    output logic [7:0] result,
    output logic       busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic               fv_s1_q, fv_s2_q, fv_s3_q;
    logic               frame_stb;
    logic               push_req, set_ill, clr_err;
    logic [1:0]         push_kind;
    cmd_entry_t         push_entry;
    cmd_entry_t         head_entry;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]      fifo_count;
    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    cmd_entry_t         issue_q, issue_d;
    logic               set_to, capture_res;
    logic               ovf_q, ill_q, to_q;
    logic [7:0]         status_q, result_q;
    logic [4:0]         cnt_wide;
    logic [2:0]         cnt_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_s1_q <= 1'b0;
            fv_s2_q <= 1'b0;
            fv_s3_q <= 1'b0;
        end else begin
            fv_s1_q <= frame_valid;
            fv_s2_q <= fv_s1_q;
            fv_s3_q <= fv_s2_q;
        end
    end

    assign frame_stb = fv_s2_q && !fv_s3_q;

    always_comb begin
        push_req  = 1'b0;
        set_ill   = 1'b0;
        clr_err   = 1'b0;
        push_kind = KIND_WRITE;
        if (frame_stb) begin
            case (frame_cmd)
                CMD_NOP:     push_req = 1'b0;
                CMD_WRITE:   begin push_req = 1'b1; push_kind = KIND_WRITE;   end
                CMD_COMPUTE: begin push_req = 1'b1; push_kind = KIND_COMPUTE; end
                CMD_READ:    begin push_req = 1'b1; push_kind = KIND_READ;    end
                CMD_CLR_ERR: clr_err = 1'b1;
                default:     set_ill = 1'b1;
            endcase
        end
    end

    assign push_entry = {push_kind, frame_tile_i, frame_tile_j, frame_op, frame_data};
    assign head_entry = cmd_entry_t'(fifo_rdata);

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Ack/done in the last allowed cycle still beats the timeout.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        issue_d     = issue_q;
        fifo_pop    = 1'b0;
        set_to      = 1'b0;
        capture_res = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    issue_d  = head_entry;
                    timer_d  = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (eng_ack) begin
                    timer_d = '0;
                    state_d = (issue_q.kind == KIND_WRITE) ? ST_IDLE : ST_WAIT_DONE;
                end else if (timer_q == TLAST) begin
                    set_to  = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (eng_done) begin
                    capture_res = (issue_q.kind == KIND_READ);
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else if (timer_q == TLAST) begin
                    set_to  = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_wide = 5'(fifo_count);
    assign cnt_sat  = (cnt_wide > 5'd7) ? 3'd7 : cnt_wide[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            issue_q  <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            to_q     <= 1'b0;
            status_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            issue_q  <= issue_d;
            ovf_q    <= (push_req && fifo_full) || (ovf_q && !clr_err);
            ill_q    <= set_ill || (ill_q && !clr_err);
            to_q     <= set_to || (to_q && !clr_err);
            status_q[STAT_BUSY]    <= busy;
            status_q[STAT_OVF]     <= ovf_q;
            status_q[STAT_ILLEGAL] <= ill_q;
            status_q[STAT_TIMEOUT] <= to_q;
            status_q[STAT_FULL]    <= fifo_full;
            status_q[2:0]          <= cnt_sat;
            if (capture_res) result_q <= eng_result;
        end
    end

    assign eng_req    = (state_q == ST_ISSUE);
    assign eng_kind   = issue_q.kind;
    assign eng_op     = issue_q.op;
    assign eng_tile_i = issue_q.tile_i;
    assign eng_tile_j = issue_q.tile_j;
    assign eng_data   = issue_q.data;
    assign status     = status_q;
    assign result     = result_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: doc/npu_cmd_scheduler.md
# npu_cmd_scheduler

Clock-domain-side command scheduler for the NPU. Takes decoded SPI frames (cmd, tile coordinates, op code, data byte) from the SPI slave, synchronises the frame strobe into `clk`, queues legal commands in a small FIFO, and sequences them one at a time onto the tile engine over a req/ack + done handshake. Returns a status byte and the last read result for the SPI slave's `data_out`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command queue entries; power of two, 2..16.
- `TIMEOUT`, 255: cycles allowed for each `eng_ack` wait and each `eng_done` wait.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_valid`  in  1  SPI frame strobe, `sclk` domain. Level signal; rises when a frame completes.
- `frame_cmd`  in  8  command byte; stable while `frame_valid` is high.
- `frame_tile_i`, `frame_tile_j`  in  3 each  tile coordinates.
- `frame_op`  in  3  engine op code.
- `frame_data`  in  8  data byte.
- `eng_req`  out  1  command request to the tile engine.
- `eng_kind`  out  2  1 = WRITE, 2 = COMPUTE, 3 = READ.
- `eng_op`  out  3  op code; valid while `eng_req` is high.
- `eng_tile_i`, `eng_tile_j`  out  3 each  tile coordinates; valid while `eng_req` is high.
- `eng_data`  out  8  data byte; valid while `eng_req` is high.
- `eng_ack`  in  1  engine accepted the request.
- `eng_done`  in  1  single-cycle pulse: COMPUTE/READ finished.
- `eng_result`  in  8  result byte; valid in the `eng_done` cycle.
- `status`  out  8  bit 7 busy, bit 6 overflow, bit 5 illegal, bit 4 timeout, bit 3 fifo_full, bits 2:0 fifo count (saturating at 7).
- `result`  out  8  last READ result.
- `busy`  out  1  state is not IDLE, or FIFO is not empty.

## Operation
- **Sync.** `frame_valid` passes through two flops, then a third flop for rising-edge detect. This produces a one-cycle `frame_stb`. All `frame_*` fields are sampled in the `frame_stb` cycle.
- **Decode at strobe.**
  - `cmd` 0x01, 0x02, 0x03: pushed to the FIFO as kind 1, 2 or 3, together with tile_i, tile_j, op and data.
  - 0x00 (NOP / status poll): no action.
  - 0xFF: clears the overflow, illegal and timeout bits.
  - Any other value: sets the illegal bit; the frame is dropped.
- **Overflow.** A push while the FIFO is full (full as registered at the start of the cycle, even if a pop occurs in the same cycle) drops the frame and sets the overflow bit.
- **Error bits.** All error bits are sticky. If a set and an 0xFF clear occur in the same cycle, the set wins.
- **FSM states:** IDLE, ISSUE, WAIT_DONE.
  - IDLE: if the FIFO is not empty, pop the head into the issue registers, go to ISSUE.
  - ISSUE: `eng_req` = 1 and the `eng_*` outputs are driven from the issue registers. On `eng_ack`:
    - WRITE goes to IDLE.
    - COMPUTE and READ go to WAIT_DONE.
  - WAIT_DONE: `eng_req` = 0. On `eng_done`, go to IDLE; for READ, also capture `result <= eng_result`.
- **Timeout.** The timer clears on each state entry and increments every cycle in ISSUE and WAIT_DONE. When it reaches `TIMEOUT`, set the timeout bit, drop `eng_req`, go to IDLE, and discard the command.
- **Ignored inputs.** `eng_done` outside WAIT_DONE is ignored. `eng_ack` outside ISSUE is ignored.

## Timing
- **Reset values.** All outputs are 0, the FIFO is empty, the state is IDLE and the error bits are clear. Reset asserted mid-transaction drops `eng_req` immediately (asynchronously) and discards the queue.
- **Strobe latency.** From the `frame_valid` rising edge to the FIFO push is 3 `clk` edges. The FIFO count in `status` updates 1 cycle after the push.
- **Issue latency.** From the push into an empty FIFO with the FSM idle to `eng_req` high is 2 cycles: pop in IDLE, ISSUE on the next edge.
- **Request hold.** `eng_req` stays high until the cycle in which `eng_ack` is sampled high, and falls on the next edge. `eng_*` payload is stable throughout.
- **Back-to-back.** The minimum gap between consecutive WRITE requests is 1 cycle of `eng_req` low (the IDLE cycle).
- `result` updates on the edge after `eng_done`. `status` is fully registered.

## Structure
- Package `npu_cmd_pkg` holds:
  - the command byte constants (NOP, WRITE, COMPUTE, READ, CLR_ERR);
  - the `eng_kind` encodings;
  - the FSM state enum;
  - the status bit index constants;
  - a packed `cmd_entry_t` struct {kind, tile_i, tile_j, op, data}, 19 bits.
- Sub-module `cmd_fifo`: a synchronous FIFO of `cmd_entry_t`, `FIFO_DEPTH` entries, with push/pop, full/empty and count outputs. The synchroniser and FSM stay in the top module.

## Test plan
- **WRITE.** Frame with cmd 0x01, tile (2,5), data 0x3C; engine acks 1 cycle after request → one `eng_req` pulse with kind 1, tile 2/5, `eng_data` 0x3C; `busy` returns to 0.
- **READ.** Frame 0x03; ack after 2 cycles, `eng_done` with `eng_result` 0xA5 ten cycles later → `result` = 0xA5; `status` = 0x00 once idle.
- **Timeout.** With `TIMEOUT` = 16, send COMPUTE (0x02); ack it, never assert `eng_done` → after 16 cycles in WAIT_DONE, `status` bit 4 is set and the FSM is back in IDLE. A subsequent 0xFF frame clears the bit.
- **Overflow.** With `FIFO_DEPTH` = 4 and `eng_ack` held low, send 6 WRITE frames → 1 in ISSUE, 4 queued, 1 dropped; `status` = 0xCC (busy, overflow, full, count 4).
- **Illegal command.** Frame 0x7E → `status` bit 5 set, no `eng_req`. Then a 0xFF frame coinciding with a second 0x7E frame is impossible (frames are serial), so instead check: 0xFF clears the bit, and 0x00 leaves `status` unchanged.
- **Reset mid-op.** Assert `rst_n` low while `eng_req` is high with 2 entries queued → `eng_req` = 0 immediately; after release, `status` = 0x00 and no requests are issued.
